// File: rtl/adc_sample_conditioner.sv
// -----------------------------------------------------------------------------
// adc_sample_conditioner
//
// Takes 16-bit frames from the SPI ADC master, extracts the ADC_BITS-wide
// offset-binary sample, converts it to left-aligned two's complement and queues
// it in a small first-word-fall-through FIFO for the equalizer filter bank.
//
// Ports
//   clk           system clock, rising edge
//   rst           asynchronous reset, active low
//   adc_data      16-bit frame, stable while adc_ready is high
//   adc_ready     frame-done (level or pulse); rising edge starts a capture
//   sample_out    FIFO head, signed two's complement (0 while empty)
//   sample_valid  FIFO not empty
//   sample_accept consumer pops the head when sample_valid && sample_accept
//   fifo_level    number of stored entries, 0..DEPTH
//   overflow      sticky: a sample was dropped because the FIFO was full
//   overflow_clr  clears overflow (a simultaneous new overflow wins)
//   frame_err     one-cycle pulse: captured frame had bits set above ADC_BITS
//
// Optional build macro ADC_COND_AVG2_EN: converted samples are averaged in
// pairs (decimate by 2) before entering the FIFO, one cycle later than the
// plain path.
// -----------------------------------------------------------------------------
module adc_sample_conditioner #(
  parameter int ADC_BITS = 12,
  parameter int OUT_W    = 16,
  parameter int DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [15:0]              adc_data,
  input  logic                     adc_ready,
  output logic [OUT_W-1:0]         sample_out,
  output logic                     sample_valid,
  input  logic                     sample_accept,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow,
  input  logic                     overflow_clr,
  output logic                     frame_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  // ---------------------------------------------------------------------------
  // Edge detect and conversion stage
  // ---------------------------------------------------------------------------
  logic                adc_ready_d;
  logic                capture;
  logic [ADC_BITS-1:0] raw;
  logic [OUT_W-1:0]    conv_next;
  logic                hi_bits_set;
  logic [OUT_W-1:0]    conv_q;
  logic                conv_vld;

  assign capture = adc_ready && !adc_ready_d;
  assign raw     = adc_data[ADC_BITS-1:0];

  // Offset-binary to two's complement is an MSB flip; then left-align.
  assign conv_next = OUT_W'({~raw[ADC_BITS-1], raw[ADC_BITS-2:0]}) << (OUT_W - ADC_BITS);

  // Any frame bit above the sample field marks a malformed frame.
  assign hi_bits_set = (adc_data >> ADC_BITS) != 16'd0;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbours, regardless of block order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      adc_ready_d <= 1'b0;
      conv_q      <= '0;
      conv_vld    <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      adc_ready_d <= adc_ready;
      conv_vld    <= capture;
      frame_err   <= capture && hi_bits_set;
      if (capture) conv_q <= conv_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Write source: plain path or pairwise average
  // ---------------------------------------------------------------------------
  logic             wr_en;
  logic [OUT_W-1:0] wr_data;

`ifdef ADC_COND_AVG2_EN
  logic             pair_second;
  logic [OUT_W-1:0] held_q;
  logic [OUT_W-1:0] avg_q;
  logic             avg_vld;
  logic [OUT_W:0]   pair_sum;

  // Sign-extended sum in OUT_W+1 bits; taking [OUT_W:1] is the >>>1.
  assign pair_sum = {held_q[OUT_W-1], held_q} + {conv_q[OUT_W-1], conv_q};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pair_second <= 1'b0;
      held_q      <= '0;
      avg_q       <= '0;
      avg_vld     <= 1'b0;
    end else begin
      avg_vld <= 1'b0;
      if (conv_vld) begin
        if (!pair_second) begin
          held_q      <= conv_q;
          pair_second <= 1'b1;
        end else begin
          avg_q       <= pair_sum[OUT_W:1];
          avg_vld     <= 1'b1;
          pair_second <= 1'b0;
        end
      end
    end
  end

  assign wr_en   = avg_vld;
  assign wr_data = avg_q;
`else
  assign wr_en   = conv_vld;
  assign wr_data = conv_q;
`endif

  // ---------------------------------------------------------------------------
  // First-word-fall-through FIFO
  // ---------------------------------------------------------------------------
  logic [OUT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level;
  logic             full;
  logic             pop;
  logic             push;
  logic             drop;

  assign full         = (level == LVL_W'(DEPTH));
  assign sample_valid = (level != '0);
  assign pop          = sample_valid && sample_accept;
  // A pop in the same cycle frees the slot a full FIFO needs.
  assign push         = wr_en && (!full || pop);
  assign drop         = wr_en && full && !pop;

  // NOTE: the storage array has no reset; the pointers and level define which
  // entries are meaningful, and sample_out is forced to 0 while empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (drop)              overflow <= 1'b1;
      else if (overflow_clr) overflow <= 1'b0;
    end
  end

  assign sample_out = sample_valid ? mem[rd_ptr] : '0;
  assign fifo_level = level;

endmodule

// File: tb/tb_adc_sample_conditioner.sv
// -----------------------------------------------------------------------------
// tb_adc_sample_conditioner
//
// Directed bench for adc_sample_conditioner (default parameters, DEPTH=4).
// Inputs change 1 ns after a rising edge; outputs are checked at that point,
// i.e. after the edge has settled. A table of single frames covers the
// conversion and frame_err; hand-written sequences cover streaming, level
// capture, overflow, full-with-pop, and reset behaviour. When compiled with
// ADC_COND_AVG2_EN the pairwise-average sequence replaces the plain-path ones.
// -----------------------------------------------------------------------------
module tb_adc_sample_conditioner;

  logic        clk;
  logic        rst;
  logic [15:0] adc_data;
  logic        adc_ready;
  logic [15:0] sample_out;
  logic        sample_valid;
  logic        sample_accept;
  logic [2:0]  fifo_level;
  logic        overflow;
  logic        overflow_clr;
  logic        frame_err;

  int checks = 0;
  int errors = 0;

  adc_sample_conditioner dut (
    .clk          (clk),
    .rst          (rst),
    .adc_data     (adc_data),
    .adc_ready    (adc_ready),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .sample_accept(sample_accept),
    .fifo_level   (fifo_level),
    .overflow     (overflow),
    .overflow_clr (overflow_clr),
    .frame_err    (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    logic [15:0] exp_sample;
    logic        exp_err;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle adc_ready pulse; on return the frame is in the conv register
  // and will be written to the FIFO on the next edge.
  task automatic send_frame(input logic [15:0] d);
    adc_data  = d;
    adc_ready = 1'b1;
    tick();
    adc_ready = 1'b0;
    tick();
  endtask

  task automatic pop_check(input string name, input logic [15:0] exp);
    check(name, {16'd0, sample_out}, {16'd0, exp});
    sample_accept = 1'b1;
    tick();
    sample_accept = 1'b0;
  endtask

  initial begin
    vecs[0] = '{16'h0800, 16'h0000, 1'b0};
    vecs[1] = '{16'h0FFF, 16'h7FF0, 1'b0};
    vecs[2] = '{16'h0000, 16'h8000, 1'b0};
    vecs[3] = '{16'h0ABC, 16'h2BC0, 1'b0};
    vecs[4] = '{16'hF800, 16'h0000, 1'b1};
    vecs[5] = '{16'h07FF, 16'hFFF0, 1'b0};
    vecs[6] = '{16'h1001, 16'h8010, 1'b1};

    rst           = 1'b0;
    adc_data      = 16'h0000;
    adc_ready     = 1'b0;
    sample_accept = 1'b0;
    overflow_clr  = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_valid",    {31'd0, sample_valid}, 32'd0);
    check("rst_level",    {29'd0, fifo_level},   32'd0);
    check("rst_sample",   {16'd0, sample_out},   32'd0);
    check("rst_overflow", {31'd0, overflow},     32'd0);
    check("rst_frame_err",{31'd0, frame_err},    32'd0);

    rst = 1'b1;
    tick();

    // Accept while empty must not underflow
    sample_accept = 1'b1;
    tick();
    sample_accept = 1'b0;
    check("empty_accept_level", {29'd0, fifo_level},   32'd0);
    check("empty_accept_valid", {31'd0, sample_valid}, 32'd0);

`ifdef ADC_COND_AVG2_EN
    // Pairwise average: 0x7FF0 and 0x0010 -> 0x4000
    send_frame(16'h0FFF);
    repeat (2) tick();
    check("avg_first_held", {29'd0, fifo_level}, 32'd0);
    send_frame(16'h0801);
    repeat (2) tick();
    check("avg_level",  {29'd0, fifo_level}, 32'd1);
    check("avg_sample", {16'd0, sample_out}, 32'h4000);
    send_frame(16'h0ABC);
    repeat (4) tick();
    check("avg_lone_frame", {29'd0, fifo_level}, 32'd1);
    pop_check("avg_pop", 16'h4000);
    check("avg_drained", {29'd0, fifo_level}, 32'd0);
`else
    // Table: single frames through an empty FIFO
    for (int i = 0; i < 7; i++) begin
      adc_data  = vecs[i].data;
      adc_ready = 1'b1;
      tick();                       // capture edge
      adc_ready = 1'b0;
      check($sformatf("vec%0d_valid_early", i), {31'd0, sample_valid}, 32'd0);
      check($sformatf("vec%0d_frame_err", i),   {31'd0, frame_err},    {31'd0, vecs[i].exp_err});
      tick();                       // FIFO write edge
      check($sformatf("vec%0d_frame_err_end", i), {31'd0, frame_err},  32'd0);
      check($sformatf("vec%0d_valid", i),       {31'd0, sample_valid}, 32'd1);
      check($sformatf("vec%0d_level", i),       {29'd0, fifo_level},   32'd1);
      check($sformatf("vec%0d_sample", i),      {16'd0, sample_out},   {16'd0, vecs[i].exp_sample});
      sample_accept = 1'b1;
      tick();
      sample_accept = 1'b0;
      check($sformatf("vec%0d_drained", i),     {29'd0, fifo_level},   32'd0);
    end

    // Streaming with sample_accept held high
    sample_accept = 1'b1;
    adc_data  = 16'h0FFF;
    adc_ready = 1'b1;
    tick();
    adc_ready = 1'b0;
    tick();                         // write into empty while accept is high
    check("stream_a_valid",  {31'd0, sample_valid}, 32'd1);
    check("stream_a_level",  {29'd0, fifo_level},   32'd1);
    check("stream_a_sample", {16'd0, sample_out},   32'h7FF0);
    adc_data  = 16'h0000;
    adc_ready = 1'b1;
    tick();                         // pop of first, capture of second
    adc_ready = 1'b0;
    check("stream_gap_valid", {31'd0, sample_valid}, 32'd0);
    tick();
    check("stream_b_valid",  {31'd0, sample_valid}, 32'd1);
    check("stream_b_sample", {16'd0, sample_out},   32'h8000);
    tick();
    check("stream_end_level", {29'd0, fifo_level},  32'd0);
    sample_accept = 1'b0;

    // Level held high: exactly one capture
    adc_data  = 16'h0ABC;
    adc_ready = 1'b1;
    repeat (20) tick();
    adc_ready = 1'b0;
    tick();
    check("level_hold_count",  {29'd0, fifo_level}, 32'd1);
    pop_check("level_hold_sample", 16'h2BC0);
    check("level_hold_drained", {29'd0, fifo_level}, 32'd0);

    // Overflow: five frames into a four-entry FIFO
    for (int k = 1; k <= 5; k++) send_frame(16'(k));
    tick();
    check("ovf_level", {29'd0, fifo_level}, 32'd4);
    check("ovf_flag",  {31'd0, overflow},   32'd1);
    pop_check("ovf_head0", 16'h8010);
    pop_check("ovf_head1", 16'h8020);
    pop_check("ovf_head2", 16'h8030);
    pop_check("ovf_head3", 16'h8040);
    check("ovf_drained", {29'd0, fifo_level}, 32'd0);
    check("ovf_sticky",  {31'd0, overflow},   32'd1);
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    check("ovf_cleared", {31'd0, overflow}, 32'd0);

    // Full FIFO with a pop coinciding with the write
    for (int k = 6; k <= 9; k++) send_frame(16'(k));
    tick();
    check("full_level", {29'd0, fifo_level}, 32'd4);
    adc_data  = 16'd10;
    adc_ready = 1'b1;
    tick();                         // capture
    adc_ready     = 1'b0;
    sample_accept = 1'b1;
    tick();                         // write and pop together
    sample_accept = 1'b0;
    check("full_pop_level",    {29'd0, fifo_level}, 32'd4);
    check("full_pop_overflow", {31'd0, overflow},   32'd0);
    pop_check("full_pop_head0", 16'h8070);
    pop_check("full_pop_head1", 16'h8080);
    pop_check("full_pop_head2", 16'h8090);
    pop_check("full_pop_head3", 16'h80A0);
    check("full_pop_drained", {29'd0, fifo_level}, 32'd0);

    // Reset mid-operation, with adc_ready high across release
    send_frame(16'h0123);
    send_frame(16'h0456);
    adc_data  = 16'h0800;
    adc_ready = 1'b1;
    tick();                         // third frame now in the conv register
    #2 rst = 1'b0;
    #1;
    check("midrst_level",  {29'd0, fifo_level},   32'd0);
    check("midrst_valid",  {31'd0, sample_valid}, 32'd0);
    check("midrst_sample", {16'd0, sample_out},   32'd0);
    repeat (2) tick();
    check("midrst_held_level", {29'd0, fifo_level}, 32'd0);
    rst = 1'b1;
    tick();                         // capture on first clock after release
    check("release_valid_early", {31'd0, sample_valid}, 32'd0);
    tick();
    adc_ready = 1'b0;
    check("release_level",  {29'd0, fifo_level}, 32'd1);
    check("release_sample", {16'd0, sample_out}, 32'h0000);
    repeat (3) tick();
    check("release_single", {29'd0, fifo_level}, 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_sample_conditioner.md
Name: adc_sample_conditioner

Overview:
- Sits directly downstream of the SPI ADC master and consumes its 16-bit frame and frame-done strobe.
- Extracts the ADC_BITS-wide sample field and converts it from offset-binary to left-aligned two's complement.
- Buffers samples in a small first-word-fall-through FIFO with a valid/accept handshake toward the equalizer filter bank.
- Flags overflow and malformed frames.

Parameters:
ADC_BITS, 12, width of the sample field in adc_data[ADC_BITS-1:0]; must be ≤ 16 and ≤ OUT_W.
OUT_W, 16, output sample width; sample is left-aligned and low bits are zero-filled.
DEPTH, 4, FIFO depth in entries; power of 2, ≥ 2.

Ports:
clk  input  1  system clock; all logic on the rising edge
rst  input  1  asynchronous, active-low reset
adc_data  input  16  frame from SPI master; stable while adc_ready is high
adc_ready  input  1  frame-done from SPI master; level or pulse, rising edge detected internally
sample_out  output  OUT_W  FIFO head, signed two's complement
sample_valid  output  1  FIFO not empty
sample_accept  input  1  consumer pops the head when sample_valid && sample_accept
fifo_level  output  $clog2(DEPTH)+1  entries currently stored
overflow  output  1  sticky: sample dropped because FIFO full
overflow_clr  input  1  clears overflow
frame_err  output  1  one-cycle pulse: captured frame had nonzero bits above ADC_BITS

Behaviour:
- Reset (rst=0, asynchronous):
  - All outputs 0; sample_out 0.
  - FIFO empty, pointers 0, edge-detect history 0, pipeline register invalid.
- Edge detect:
  - capture = adc_ready && !adc_ready_d, where adc_ready_d is the registered adc_ready.
  - A level held high for many cycles yields exactly one capture.
  - adc_ready already high when reset is released yields a capture on the first clock after release.
- Conversion stage, registered on capture:
  - raw = adc_data[ADC_BITS-1:0]; conv = {~raw[ADC_BITS-1], raw[ADC_BITS-2:0]} << (OUT_W-ADC_BITS).
  - conv_vld set for one cycle.
  - frame_err pulses in the same cycle as conv_vld if adc_data[15:ADC_BITS] != 0. The sample is still converted and written.
- Latency:
  - capture in cycle N; conv register loaded at the end of N; FIFO written at the end of N+1.
  - sample_valid is high in cycle N+2 if the FIFO was empty, so 2 cycles from the first adc_ready-high cycle.
- FIFO, first-word fall-through:
  - sample_out always shows the head entry; its value is don't-care while empty.
  - Pop when sample_valid && sample_accept. Accept while empty is ignored and does not underflow.
  - Write when full with no pop in the same cycle: the new sample is dropped, contents unchanged, overflow set.
  - Write when full with a pop in the same cycle: both occur, level stays DEPTH, no overflow.
  - Write and pop both into an empty FIFO: the write proceeds, the pop is ignored, level becomes 1.
  - Pointers wrap modulo DEPTH; fifo_level counts 0..DEPTH.
- overflow:
  - Sticky until overflow_clr.
  - If overflow_clr and a new overflow occur in the same cycle, set wins and overflow stays 1.
- Reset mid-operation: FIFO contents discarded and the in-flight conv sample lost; no partial state survives.

Optional Feature:
- Macro ADC_COND_AVG2_EN.
- Defined:
  - Converted samples are averaged in pairs (decimate by 2).
  - The first sample of a pair is held internally. On the second, (a+b)>>>1 is computed in OUT_W+1 bits with arithmetic shift and written to the FIFO one cycle later than the non-averaged path.
  - Pair phase resets to "first" on rst.
  - frame_err still pulses per frame.
- Undefined: every converted sample is written individually, as described above.

Test Plan:
- Reset then adc_data=0x0800, adc_ready pulse 1 cycle → sample_valid rises 2 cycles later, sample_out=0x0000, fifo_level=1, frame_err=0.
- Frames 0x0FFF then 0x0000 with sample_accept=1 → sample_out 0x7FF0 then 0x8000, each valid once, fifo_level returns to 0.
- adc_ready held high 20 cycles with adc_data=0x0ABC → exactly one entry written, value 0x2BC0.
- 5 frames with sample_accept=0, DEPTH=4 → fifo_level=4, overflow=1, first 4 samples retained in order; pulse overflow_clr → overflow=0. Repeat with a pop coinciding with the 5th write → no overflow.
- adc_data=0xF800 → frame_err one-cycle pulse, sample_out=0x0000 still written.
- ADC_COND_AVG2_EN: frames 0x0FFF, 0x0801 → single entry (0x7FF0+0x0010)>>>1=0x4000; a third lone frame writes nothing.
